// File: rtl/shift_add_mult_seq.sv
// Sequencer and X:A:B register datapath for a signed WIDTH x WIDTH shift-add
// multiplier that drives an external WIDTH+1-bit add/sub stage.
module shift_add_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] Sum,
    input  logic             X_in,
    output logic [WIDTH-1:0] Add_A,
    output logic [WIDTH-1:0] Add_B,
    output logic             Add,
    output logic             Sub,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             Done,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             x_q, x_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_step;

    assign last_step = (cnt_q == LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            x_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        Add     = 1'b0;
        Sub     = 1'b0;
        case (state_q)
            IDLE: begin
                // Run takes priority over ClearA_LoadB; B keeps the multiplier.
                if (Run) begin
                    a_d     = '0;
                    x_d     = 1'b0;
                    m_d     = S;
                    cnt_d   = '0;
                    state_d = ADD;
                end else if (ClearA_LoadB) begin
                    a_d = '0;
                    x_d = 1'b0;
                    b_d = S;
                end
            end
            ADD: begin
                // The sign bit of the multiplier carries weight -2^(W-1): subtract.
                Add = b_q[0] & ~last_step;
                Sub = b_q[0] & last_step;
                if (b_q[0]) begin
                    a_d = Sum;
                    x_d = X_in;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d = {x_q, a_q[WIDTH-1:1]};
                b_d = {a_q[0], b_q[WIDTH-1:1]};
                if (last_step) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ADD;
                end
            end
            DONE: begin
                if (!Run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Add_A     = a_q;
    assign Add_B     = m_q;
    assign Aval      = a_q;
    assign Bval      = b_q;
    assign Xval      = x_q;
    assign Done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Directed bench for shift_add_mult_seq with a behavioural 9-bit add/sub stage.
module tb_shift_add_mult_seq;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       clr_ld;
    logic [7:0] s;
    logic [7:0] sum;
    logic       x_in;
    logic [7:0] add_a, add_b, aval, bval;
    logic       add, sub, xval, done;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int sub_cnt = 0;

    logic [8:0] stage_res;

    shift_add_mult_seq #(.WIDTH(8)) dut (
        .Clk(clk), .Reset_n(rst_n), .Run(run), .ClearA_LoadB(clr_ld),
        .S(s), .Sum(sum), .X_in(x_in), .Add_A(add_a), .Add_B(add_b),
        .Add(add), .Sub(sub), .Aval(aval), .Bval(bval), .Xval(xval),
        .Done(done), .dbg_state(dbg_state)
    );

    // External add/sub stage: sign-extended 9-bit A +/- M.
    assign stage_res = sub ? ({add_a[7], add_a} - {add_b[7], add_b})
                           : ({add_a[7], add_a} + {add_b[7], add_b});
    assign sum  = stage_res[7:0];
    assign x_in = stage_res[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && add && sub) begin
            errors++;
            $display("FAIL add_sub_exclusive: Add=%b Sub=%b required not both 1", add, sub);
        end
        if (rst_n && sub) sub_cnt++;
    end

    task automatic load_b(input logic [7:0] v);
        @(negedge clk);
        clr_ld = 1'b1; s = v;
        @(negedge clk);
        clr_ld = 1'b0;
    endtask

    // Start with multiplicand m; returns cycles from start edge to Done (-1 on timeout).
    task automatic start_and_wait(input logic [7:0] m, output int lat);
        @(negedge clk);
        run = 1'b1; s = m; sub_cnt = 0;
        @(posedge clk);
        lat = -1;
        #2 s = 8'hA5;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_run();
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_result(input string name, input logic [7:0] ea,
                                input logic [7:0] eb, input logic ex);
        checks++;
        if ({xval, aval, bval} !== {ex, ea, eb}) begin
            errors++;
            $display("FAIL %s: X:A:B=%b:%h:%h required %b:%h:%h", name, xval, aval, bval, ex, ea, eb);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; clr_ld = 1'b0; s = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({xval, aval, bval, done, add, sub} !== 20'h0) begin
            errors++;
            $display("FAIL reset_state: X=%b A=%h B=%h Done=%b Add=%b Sub=%b required all 0",
                     xval, aval, bval, done, add, sub);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle: state=%0d required 0", dbg_state);
        end
    endtask

    task automatic test_mid_reset();
        load_b(8'h07);
        @(negedge clk);
        run = 1'b1; s = 8'h3B;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({xval, aval, bval, done, add, sub} !== 20'h0) begin
            errors++;
            $display("FAIL mid_reset_async: X=%b A=%h B=%h Done=%b Add=%b Sub=%b required all 0",
                     xval, aval, bval, done, add, sub);
        end
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dbg_state !== 2'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: state=%0d Done=%b required 0 0", dbg_state, done);
        end
    endtask

    task automatic test_positive();
        int lat;
        load_b(8'h07);
        checks++;
        if (bval !== 8'h07 || aval !== 8'h00) begin
            errors++;
            $display("FAIL load_b: A=%h B=%h required 00 07", aval, bval);
        end
        start_and_wait(8'h3B, lat);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL latency_pos: %0d cycles required 16", lat);
        end
        check_result("result_pos_413", 8'h01, 8'h9D, 1'b0);
        checks++;
        if (sub_cnt !== 0) begin
            errors++;
            $display("FAIL sub_count_pos: %0d pulses required 0", sub_cnt);
        end
        checks++;
        if (add_b !== 8'h3B) begin
            errors++;
            $display("FAIL m_latched: Add_B=%h required 3b", add_b);
        end
    endtask

    task automatic test_hold_restart();
        int lat;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || {xval, aval, bval} !== {1'b0, 16'h019D}) begin
                errors++;
                $display("FAIL hold_no_restart: cycle %0d Done=%b X:A:B=%b:%h:%h required 1 0:01:9d",
                         i, done, xval, aval, bval);
            end
        end
        @(negedge clk);
        clr_ld = 1'b1; s = 8'h11;
        @(negedge clk);
        clr_ld = 1'b0;
        checks++;
        if (bval !== 8'h9D || done !== 1'b1) begin
            errors++;
            $display("FAIL done_ignores_load: B=%h Done=%b required 9d 1", bval, done);
        end
        release_run();
        checks++;
        if (dbg_state !== 2'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL done_to_idle: state=%0d Done=%b required 0 0", dbg_state, done);
        end
        start_and_wait(8'h02, lat);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL latency_restart: %0d cycles required 16", lat);
        end
        check_result("result_restart_m198", 8'hFF, 8'h3A, 1'b1);
        release_run();
    endtask

    task automatic test_negative();
        int lat;
        load_b(8'hF9);
        start_and_wait(8'h3B, lat);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL latency_neg: %0d cycles required 16", lat);
        end
        check_result("result_neg_m413", 8'hFE, 8'h63, 1'b1);
        checks++;
        if (sub_cnt !== 1) begin
            errors++;
            $display("FAIL sub_count_neg: %0d pulses required 1", sub_cnt);
        end
        release_run();
    endtask

    task automatic test_min_min();
        int lat;
        load_b(8'h80);
        start_and_wait(8'h80, lat);
        check_result("result_min_16384", 8'h40, 8'h00, 1'b0);
        checks++;
        if (sub_cnt !== 1) begin
            errors++;
            $display("FAIL sub_count_min: %0d pulses required 1", sub_cnt);
        end
        release_run();
    endtask

    task automatic test_run_priority();
        int lat;
        load_b(8'h07);
        @(negedge clk);
        clr_ld = 1'b1;
        start_and_wait(8'h55, lat);
        clr_ld = 1'b0;
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL latency_prio: %0d cycles required 16", lat);
        end
        check_result("result_prio_595", 8'h02, 8'h53, 1'b0);
        release_run();
    endtask

    initial begin
        test_reset();
        test_mid_reset();
        test_positive();
        test_hold_restart();
        test_negative();
        test_min_min();
        test_run_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
